// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with standard or first-word-fall-through read mode,
// occupancy count, programmable almost flags, sticky error flags and flush.
module sync_fifo_flags #(
  parameter int DSIZE      = 8,
  parameter int ASIZE      = 4,
  parameter int FWFT       = 0,
  parameter int AFULL_LVL  = 12,
  parameter int AEMPTY_LVL = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rvalid,
  output logic             wfull,
  output logic             rempty,
  output logic             walmost_full,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] PTR_ONE  = {{ASIZE{1'b0}}, 1'b1};
  localparam logic [ASIZE:0] AFULL_C  = (ASIZE+1)'(AFULL_LVL);
  localparam logic [ASIZE:0] AEMPTY_C = (ASIZE+1)'(AEMPTY_LVL);

  logic [DSIZE-1:0] mem_q [DEPTH];
  logic [ASIZE:0]   wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
  logic             wfull_q, wfull_d, rempty_q, rempty_d;
  logic             walmost_full_q, walmost_full_d, ralmost_empty_q, ralmost_empty_d;
  logic             overflow_q, overflow_d, underflow_q, underflow_d;
  logic [DSIZE-1:0] rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic             wr_acc, rd_acc;

  // Next-state for pointers, occupancy, flags and read port.
  always_comb begin
    wr_acc      = winc && !wfull_q && !flush;
    rd_acc      = rinc && !rempty_q && !flush;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;

    if (flush) begin
      wptr_d      = '0;
      rptr_d      = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + PTR_ONE;
      else        wptr_d = wptr_q;
      if (rd_acc) rptr_d = rptr_q + PTR_ONE;
      else        rptr_d = rptr_q;
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + PTR_ONE;
        2'b01:   count_d = count_q - PTR_ONE;
        default: count_d = count_q;
      endcase
      overflow_d  = overflow_q  | (winc & wfull_q);
      underflow_d = underflow_q | (rinc & rempty_q);
    end

    wfull_d         = (wptr_d[ASIZE] != rptr_d[ASIZE]) &&
                      (wptr_d[ASIZE-1:0] == rptr_d[ASIZE-1:0]);
    rempty_d        = (wptr_d == rptr_d);
    walmost_full_d  = (count_d >= AFULL_C);
    ralmost_empty_d = (count_d <= AEMPTY_C);

    // FWFT presents the post-edge head; a write landing on the head slot is bypassed.
    if (FWFT != 0) begin
      rvalid_d = !rempty_d;
      if (rempty_d)
        rdata_d = rdata_q;
      else if (wr_acc && (wptr_q[ASIZE-1:0] == rptr_d[ASIZE-1:0]))
        rdata_d = wdata;
      else
        rdata_d = mem_q[rptr_d[ASIZE-1:0]];
    end else begin
      rvalid_d = rd_acc;
      if (rd_acc) rdata_d = mem_q[rptr_q[ASIZE-1:0]];
      else        rdata_d = rdata_q;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q          <= '0;
      rptr_q          <= '0;
      count_q         <= '0;
      wfull_q         <= 1'b0;
      rempty_q        <= 1'b1;
      walmost_full_q  <= 1'b0;
      ralmost_empty_q <= 1'b1;
      overflow_q      <= 1'b0;
      underflow_q     <= 1'b0;
      rdata_q         <= '0;
      rvalid_q        <= 1'b0;
    end else begin
      wptr_q          <= wptr_d;
      rptr_q          <= rptr_d;
      count_q         <= count_d;
      wfull_q         <= wfull_d;
      rempty_q        <= rempty_d;
      walmost_full_q  <= walmost_full_d;
      ralmost_empty_q <= ralmost_empty_d;
      overflow_q      <= overflow_d;
      underflow_q     <= underflow_d;
      rdata_q         <= rdata_d;
      rvalid_q        <= rvalid_d;
    end
  end

  // Storage array; contents survive reset and flush.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem_q[wptr_q[ASIZE-1:0]] <= wdata;
  end

  assign rdata         = rdata_q;
  assign rvalid        = rvalid_q;
  assign wfull         = wfull_q;
  assign rempty        = rempty_q;
  assign walmost_full  = walmost_full_q;
  assign ralmost_empty = ralmost_empty_q;
  assign count         = count_q;
  assign overflow      = overflow_q;
  assign underflow     = underflow_q;

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
- Single-clock, parametrised successor to the dual-clock 8x16 FIFO; used where producer and consumer share `clk`, so no clock divider and no pointer synchronisers.
- Adds over the previous FIFO: selectable standard or first-word-fall-through (FWFT) read mode, occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, and a synchronous flush.
- Sits between the pin-level wrapper and any datapath needing elastic buffering.

Parameters:
- DSIZE, 8, data width in bits.
- ASIZE, 4, address width; depth = 2^ASIZE words.
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.
- AFULL_LVL, 12, almost-full asserts when count >= AFULL_LVL; legal range 1..2^ASIZE.
- AEMPTY_LVL, 4, almost-empty asserts when count <= AEMPTY_LVL; legal range 0..2^ASIZE-1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of pointers, count and flags.
- wdata  input  DSIZE  write data.
- winc  input  1  write request.
- rinc  input  1  read request (FWFT: pop of the head word).
- rdata  output  DSIZE  read data.
- rvalid  output  1  rdata holds valid data.
- wfull  output  1  count == 2^ASIZE.
- rempty  output  1  count == 0 (FWFT: equals !rvalid).
- walmost_full  output  1  count >= AFULL_LVL.
- ralmost_empty  output  1  count <= AEMPTY_LVL.
- count  output  ASIZE+1  current occupancy, 0..2^ASIZE.
- overflow  output  1  sticky: a write was attempted while full.
- underflow  output  1  sticky: a read was attempted while empty.

Behaviour:
Reset and flush
- rst is synchronous, active-high, and has top priority.
- On rst: wptr=rptr=0, count=0, rempty=1, wfull=0, ralmost_empty=1, walmost_full=0, overflow=0, underflow=0, rvalid=0, rdata=0.
- flush: same effect as rst, except memory contents and the rdata register are not cleared.
- flush overrides winc/rinc in the same cycle; a request in a flush cycle is dropped and sets no error flag.

Pointers and flag generation
- Pointers are ASIZE+1-bit binary; the MSB is the wrap bit.
  - Full: MSBs differ and the lower ASIZE bits are equal.
  - Empty: the pointers are equal.
- Write accepted = winc && !wfull. The word is stored at mem[wptr[ASIZE-1:0]] and wptr increments.
- Read accepted = rinc && !rempty; rptr increments.
- count update: +1 on write only, -1 on read only, unchanged on both or neither.
- All flags and count are registered and reflect state after the edge; there is no combinational path from winc/rinc to any flag.

Simultaneous and boundary events
- Full, winc=1, rinc=1: read accepted, write rejected, overflow set, count becomes 2^ASIZE-1.
- Empty, winc=1, rinc=1: write accepted, read rejected, underflow set, count becomes 1.
- Neither full nor empty, winc=1, rinc=1: both accepted, count unchanged.
- A rejected request never modifies memory or pointers.
- overflow/underflow stay set until rst or flush.

Read mode FWFT=0
- On an accepted read, rdata <= mem[rptr] at the same edge; rvalid pulses high for exactly that following cycle (latency 1).
- rdata holds its last value otherwise.

Read mode FWFT=1
- rdata = mem[rptr[ASIZE-1:0]] whenever count != 0; rvalid = !rempty.
- A word written into an empty FIFO is visible on rdata/rvalid one cycle after the write edge.
- rinc pops the head and the next word appears the following cycle.
- Capacity remains 2^ASIZE.

Wrap-around
- Pointers wrap modulo 2^(ASIZE+1).
- Data order is preserved across any number of wraps.

Test Plan:
(All with DSIZE=8, ASIZE=4, AFULL_LVL=12, AEMPTY_LVL=4.)
- Reset: assert rst 2 cycles with winc=rinc=1 -> count=0, rempty=1, ralmost_empty=1, wfull=0, overflow=underflow=0, rvalid=0.
- Fill/drain, FWFT=0: write 0x00..0x0F ->
  - walmost_full rises on the edge where count becomes 12; wfull=1 at count=16.
  - 17th write sets overflow; 16 reads return 0x00..0x0F, each with a one-cycle rvalid pulse.
  - rempty=1 afterwards, ralmost_empty rises when count becomes 4.
- Simultaneous: at count=16, winc=rinc=1 -> count=15, overflow=1. At count=0, winc=rinc=1 with wdata=0xA5 -> count=1, underflow=1. At count=5, both -> count=5, FIFO order intact.
- FWFT=1: write 0x3C into empty FIFO -> next cycle rvalid=1, rdata=0x3C without rinc; rinc -> rempty=1 next cycle.
- Wrap: 40 interleaved write/read pairs of an incrementing pattern -> read data equals write sequence, count never exceeds 16, no error flags.
- Flush: at count=9, flush=1 with winc=1 -> count=0, rempty=1, overflow/underflow cleared, write dropped; a subsequent write/read of 0x77 returns 0x77.
